// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decode_pkg
// Brief    : Shared instruction field positions, register-file sizing and a
//            one-hot helper for the decode/issue slice.
// Revision : 1.0 - initial release
// ============================================================================
package decode_pkg;

  // Instruction field positions: opcode | rd | rs | rt | unused
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 21;
  localparam int RS_MSB  = 20;
  localparam int RS_LSB  = 16;
  localparam int RT_MSB  = 15;
  localparam int RT_LSB  = 11;

  localparam int NUM_REGS = 32;
  localparam int REG_W    = 5;

  // One-hot decode of a register index onto the scoreboard vector
  function automatic logic [NUM_REGS-1:0] onehot32(input logic [REG_W-1:0] r);
    logic [NUM_REGS-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

endpackage : decode_pkg
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_scoreboard
// Brief    : 32-entry write-pending scoreboard with outstanding-writer count
//            and a sticky error for writebacks to registers not pending.
// Revision : 1.0 - initial release
// ============================================================================
module reg_scoreboard
  import decode_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int WB_BYPASS       = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_reg,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_reg,
  input  logic [REG_W-1:0] rs_reg,
  input  logic [REG_W-1:0] rt_reg,
  input  logic [REG_W-1:0] rd_reg,
  output logic             rs_pend,
  output logic             rt_pend,
  output logic             rd_pend,
  output logic             wb_hit,
  output logic             at_cap,
  output logic [3:0]       outstanding,
  output logic             sb_err
);

  logic [NUM_REGS-1:0] r_sb;
  logic [3:0]          r_outstanding;
  logic                r_sb_err;

  logic                w_wb_live;
  logic [NUM_REGS-1:0] w_wbmask;
  logic [NUM_REGS-1:0] w_setmask;
  logic [NUM_REGS-1:0] w_eff;
  logic                w_set_live;

  // Writeback mask, set mask and the bypass-adjusted view used for hazard lookups
  always_comb begin
    w_wb_live  = wb_valid & (wb_reg != '0);
    w_wbmask   = w_wb_live ? onehot32(wb_reg) : '0;
    w_set_live = set_en & (set_reg != '0);
    w_setmask  = w_set_live ? onehot32(set_reg) : '0;
    wb_hit     = w_wb_live & r_sb[wb_reg];
    w_eff      = (WB_BYPASS != 0) ? (r_sb & ~w_wbmask) : r_sb;
    rs_pend    = (rs_reg != '0) & w_eff[rs_reg];
    rt_pend    = (rt_reg != '0) & w_eff[rt_reg];
    rd_pend    = (rd_reg != '0) & w_eff[rd_reg];
    at_cap     = (r_outstanding == 4'(MAX_OUTSTANDING));
  end

  // Clear on writeback first, then set on issue so a same-register set wins
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sb          <= '0;
      r_outstanding <= 4'd0;
      r_sb_err      <= 1'b0;
    end else begin
      r_sb <= (r_sb & ~w_wbmask) | w_setmask;
      case ({w_set_live, wb_hit})
        2'b10:   r_outstanding <= r_outstanding + 4'd1;
        2'b01:   r_outstanding <= r_outstanding - 4'd1;
        default: r_outstanding <= r_outstanding;
      endcase
      if (w_wb_live && !r_sb[wb_reg]) begin
        r_sb_err <= 1'b1;
      end
    end
  end

  assign outstanding = r_outstanding;
  assign sb_err      = r_sb_err;

endmodule : reg_scoreboard
`default_nettype wire

// File: rtl/decode_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : decode_issue_ctrl
// Brief    : Single-slot decode issue controller. Holds one instruction and
//            offers it to execute only when free of RAW/WAW hazards and below
//            the outstanding-writer cap; flush discards the held slot.
// Revision : 1.0 - initial release
// ============================================================================
module decode_issue_ctrl
  import decode_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int WB_BYPASS       = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic             in_reads_rs,
  input  logic             in_reads_rt,
  input  logic             in_writes_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_writes_rd,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_reg,
  input  logic             flush,
  output logic [3:0]       outstanding,
  output logic             sb_err
);

  logic             r_slot_valid;
  logic [31:0]      r_inst;
  logic             r_reads_rs;
  logic             r_reads_rt;
  logic             r_writes_rd;

  logic [REG_W-1:0] w_rd;
  logic [REG_W-1:0] w_rs;
  logic [REG_W-1:0] w_rt;
  logic             w_rs_pend;
  logic             w_rt_pend;
  logic             w_rd_pend;
  logic             w_wb_hit;
  logic             w_at_cap;
  logic             w_hazard;
  logic             w_cap_stall;
  logic             w_issue;
  logic             w_accept;

  assign w_rd = r_inst[RD_MSB:RD_LSB];
  assign w_rs = r_inst[RS_MSB:RS_LSB];
  assign w_rt = r_inst[RT_MSB:RT_LSB];

  reg_scoreboard #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .WB_BYPASS       (WB_BYPASS)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .wb_valid    (wb_valid),
    .wb_reg      (wb_reg),
    .set_en      (w_issue & r_writes_rd),
    .set_reg     (w_rd),
    .rs_reg      (w_rs),
    .rt_reg      (w_rt),
    .rd_reg      (w_rd),
    .rs_pend     (w_rs_pend),
    .rt_pend     (w_rt_pend),
    .rd_pend     (w_rd_pend),
    .wb_hit      (w_wb_hit),
    .at_cap      (w_at_cap),
    .outstanding (outstanding),
    .sb_err      (sb_err)
  );

  // Issue decision: hazards use only held state, so there is no in->out path.
  // A writeback that retires a pending writer frees a cap slot this cycle.
  always_comb begin
    w_hazard    = (r_reads_rs & w_rs_pend) | (r_reads_rt & w_rt_pend) |
                  (r_writes_rd & w_rd_pend);
    w_cap_stall = r_writes_rd & w_at_cap & ~w_wb_hit;
    out_valid   = r_slot_valid & ~w_hazard & ~w_cap_stall & ~flush;
    w_issue     = out_valid & out_ready;
    in_ready    = ~flush & (~r_slot_valid | w_issue);
    w_accept    = in_valid & in_ready;
  end

  // Slot register: flush empties it, accept reloads, issue alone drains it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot_valid <= 1'b0;
      r_inst       <= '0;
      r_reads_rs   <= 1'b0;
      r_reads_rt   <= 1'b0;
      r_writes_rd  <= 1'b0;
    end else if (flush) begin
      r_slot_valid <= 1'b0;
    end else if (w_accept) begin
      r_slot_valid <= 1'b1;
      r_inst       <= in_inst;
      r_reads_rs   <= in_reads_rs;
      r_reads_rt   <= in_reads_rt;
      r_writes_rd  <= in_writes_rd & (in_inst[RD_MSB:RD_LSB] != '0);
    end else if (w_issue) begin
      r_slot_valid <= 1'b0;
    end
  end

  assign out_inst      = r_inst;
  assign out_writes_rd = r_writes_rd;

endmodule : decode_issue_ctrl
`default_nettype wire

// File: tb/tb_decode_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_issue_ctrl
// Brief    : Directed self-checking bench for decode_issue_ctrl
//            (MAX_OUTSTANDING=4, WB_BYPASS=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic        in_reads_rs;
  logic        in_reads_rt;
  logic        in_writes_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_writes_rd;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic        flush;
  logic [3:0]  outstanding;
  logic        sb_err;

  int          n_vec;
  int          n_err;
  logic [31:0] i1;
  logic [31:0] i2;

  decode_issue_ctrl #(
    .MAX_OUTSTANDING (4),
    .WB_BYPASS       (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_inst       (in_inst),
    .in_reads_rs   (in_reads_rs),
    .in_reads_rt   (in_reads_rt),
    .in_writes_rd  (in_writes_rd),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_writes_rd (out_writes_rd),
    .wb_valid      (wb_valid),
    .wb_reg        (wb_reg),
    .flush         (flush),
    .outstanding   (outstanding),
    .sb_err        (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [5:0] opc, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt);
    return {opc, rd, rs, rt, 11'd0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // advance to 1 time unit past the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // settle combinational outputs after changing inputs
  task automatic settle();
    #2;
  endtask

  task automatic offer(input logic v, input logic [31:0] w, input logic rrs,
                       input logic rrt, input logic wrd);
    in_valid     = v;
    in_inst      = w;
    in_reads_rs  = rrs;
    in_reads_rt  = rrt;
    in_writes_rd = wrd;
  endtask

  task automatic wb(input logic v, input logic [4:0] r);
    wb_valid = v;
    wb_reg   = r;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    offer(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    wb(1'b0, 5'd0);
    flush = 1'b0;
    tick();
    tick();
    settle();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_wr", {31'd0, out_writes_rd}, 32'd0);
    chk("rst_outstanding", {28'd0, outstanding}, 32'd0);
    chk("rst_sb_err", {31'd0, sb_err}, 32'd0);
    rst = 1'b0;

    // 1: back-to-back independent instructions
    i1 = mk(6'h01, 5'd1, 5'd2, 5'd3);
    i2 = mk(6'h02, 5'd4, 5'd5, 5'd6);
    offer(1'b1, i1, 1'b1, 1'b1, 1'b1);
    settle();
    chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    offer(1'b1, i2, 1'b1, 1'b1, 1'b1);
    settle();
    chk("t1_ov_a", {31'd0, out_valid}, 32'd1);
    chk("t1_inst_a", out_inst, i1);
    chk("t1_wr_a", {31'd0, out_writes_rd}, 32'd1);
    chk("t1_in_ready_a", {31'd0, in_ready}, 32'd1);
    tick();
    offer(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("t1_ov_b", {31'd0, out_valid}, 32'd1);
    chk("t1_inst_b", out_inst, i2);
    chk("t1_outst_b", {28'd0, outstanding}, 32'd1);
    tick();
    settle();
    chk("t1_ov_c", {31'd0, out_valid}, 32'd0);
    chk("t1_outst_c", {28'd0, outstanding}, 32'd2);
    wb(1'b1, 5'd1);
    tick();
    wb(1'b1, 5'd4);
    tick();
    wb(1'b0, 5'd0);
    settle();
    chk("t1_drain", {28'd0, outstanding}, 32'd0);
    chk("t1_no_err", {31'd0, sb_err}, 32'd0);

    // 2: RAW on r7, released by writeback with bypass
    offer(1'b1, mk(6'h03, 5'd7, 5'd0, 5'd0), 1'b0, 1'b0, 1'b1);
    tick();
    offer(1'b1, mk(6'h04, 5'd0, 5'd7, 5'd0), 1'b1, 1'b0, 1'b0);
    tick();
    offer(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("t2_stall", {31'd0, out_valid}, 32'd0);
    chk("t2_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t2_outst", {28'd0, outstanding}, 32'd1);
    tick();
    settle();
    chk("t2_stall2", {31'd0, out_valid}, 32'd0);
    wb(1'b1, 5'd7);
    settle();
    chk("t2_bypass_issue", {31'd0, out_valid}, 32'd1);
    tick();
    wb(1'b0, 5'd0);
    settle();
    chk("t2_empty", {31'd0, out_valid}, 32'd0);
    chk("t2_outst0", {28'd0, outstanding}, 32'd0);

    // 3: outstanding cap
    for (int r = 1; r <= 5; r++) begin
      offer(1'b1, mk(6'h05, 5'(r), 5'd0, 5'd0), 1'b0, 1'b0, 1'b1);
      tick();
    end
    offer(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("t3_cap_stall", {31'd0, out_valid}, 32'd0);
    chk("t3_outst4", {28'd0, outstanding}, 32'd4);
    tick();
    settle();
    chk("t3_cap_stall2", {31'd0, out_valid}, 32'd0);
    wb(1'b1, 5'd2);
    settle();
    chk("t3_cap_release", {31'd0, out_valid}, 32'd1);
    tick();
    wb(1'b0, 5'd0);
    settle();
    chk("t3_outst_kept", {28'd0, outstanding}, 32'd4);
    chk("t3_empty", {31'd0, out_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      wb(1'b1, (k == 0) ? 5'd1 : 5'(k + 2));
      tick();
    end
    wb(1'b0, 5'd0);
    settle();
    chk("t3_drain", {28'd0, outstanding}, 32'd0);
    chk("t3_no_err", {31'd0, sb_err}, 32'd0);

    // 4: r0 never hazards, wb to r0 ignored
    offer(1'b1, mk(6'h06, 5'd0, 5'd0, 5'd0), 1'b1, 1'b1, 1'b1);
    tick();
    offer(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    wb(1'b1, 5'd0);
    settle();
    chk("t4_r0_issue", {31'd0, out_valid}, 32'd1);
    chk("t4_r0_wr", {31'd0, out_writes_rd}, 32'd0);
    tick();
    wb(1'b0, 5'd0);
    settle();
    chk("t4_outst", {28'd0, outstanding}, 32'd0);
    chk("t4_no_err", {31'd0, sb_err}, 32'd0);

    // 5: flush a hazarded slot
    offer(1'b1, mk(6'h07, 5'd8, 5'd0, 5'd0), 1'b0, 1'b0, 1'b1);
    tick();
    offer(1'b1, mk(6'h08, 5'd0, 5'd8, 5'd0), 1'b1, 1'b0, 1'b0);
    tick();
    offer(1'b1, mk(6'h09, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    settle();
    chk("t5_flush_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t5_flush_ov", {31'd0, out_valid}, 32'd0);
    tick();
    flush = 1'b0;
    offer(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    wb(1'b1, 5'd8);
    settle();
    chk("t5_slot_empty", {31'd0, out_valid}, 32'd0);
    chk("t5_outst_kept", {28'd0, outstanding}, 32'd1);
    tick();
    wb(1'b0, 5'd0);
    settle();
    chk("t5_wb_ok", {31'd0, sb_err}, 32'd0);
    chk("t5_outst0", {28'd0, outstanding}, 32'd0);

    // 6: sticky error, then reset mid-stall
    wb(1'b1, 5'd9);
    tick();
    wb(1'b0, 5'd0);
    settle();
    chk("t6_err_set", {31'd0, sb_err}, 32'd1);
    chk("t6_err_outst", {28'd0, outstanding}, 32'd0);
    tick();
    settle();
    chk("t6_err_sticky", {31'd0, sb_err}, 32'd1);
    offer(1'b1, mk(6'h0a, 5'd10, 5'd0, 5'd0), 1'b0, 1'b0, 1'b1);
    tick();
    offer(1'b1, mk(6'h0b, 5'd11, 5'd10, 5'd0), 1'b1, 1'b0, 1'b1);
    tick();
    offer(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("t6_stalled", {31'd0, out_valid}, 32'd0);
    rst = 1'b1;
    tick();
    settle();
    chk("t6_rst_ov", {31'd0, out_valid}, 32'd0);
    chk("t6_rst_inst", out_inst, 32'd0);
    chk("t6_rst_wr", {31'd0, out_writes_rd}, 32'd0);
    chk("t6_rst_outst", {28'd0, outstanding}, 32'd0);
    chk("t6_rst_err", {31'd0, sb_err}, 32'd0);
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_decode_issue_ctrl
`default_nettype wire
